// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup, single-cycle update, no backpressure.
// Optional macro BTB_BYPASS_EN forwards a same-index update to the same-cycle lookup.
`timescale 1ns/1ps
module branch_target_buffer #(
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [11:0] fetch_pc,
  output logic        valid,
  output logic        prediction,
  output logic [11:0] target,
  input  logic        upd_en,
  input  logic [11:0] upd_pc,
  input  logic        upd_taken,
  input  logic [11:0] upd_target,
  input  logic        inval,
  output logic [15:0] hit_count,
  input  logic        count_en
);

  localparam int N_ENT = 1 << IDX_W;
  localparam int TAG_W = 10 - IDX_W;

  logic             r_v   [N_ENT];
  logic [TAG_W-1:0] r_tag [N_ENT];
  logic [11:0]      r_tgt [N_ENT];
  logic [1:0]       r_ctr [N_ENT];
  logic [15:0]      r_hit_cnt;

  logic [IDX_W-1:0] w_lidx;
  logic [TAG_W-1:0] w_ltag;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic [1:0]       w_nctr;
  logic [11:0]      w_ntgt;
  logic             w_rv;
  logic [TAG_W-1:0] w_rtag;
  logic [11:0]      w_rtgt;
  logic [1:0]       w_rctr;
  logic             w_hit;

  assign w_lidx = fetch_pc[IDX_W+1:2];
  assign w_ltag = fetch_pc[11:IDX_W+2];
  assign w_uidx = upd_pc[IDX_W+1:2];
  assign w_utag = upd_pc[11:IDX_W+2];

  // inval wins over the update, so a simultaneous update always sees a miss
  assign w_uhit = r_v[w_uidx] & ~inval & (r_tag[w_uidx] == w_utag);

  always_comb begin
    w_nctr = r_ctr[w_uidx];
    w_ntgt = r_tgt[w_uidx];
    if (w_uhit) begin
      if (upd_taken) begin
        if (r_ctr[w_uidx] != 2'b11) w_nctr = r_ctr[w_uidx] + 2'd1;
        w_ntgt = upd_target;
      end else if (r_ctr[w_uidx] != 2'b00) begin
        w_nctr = r_ctr[w_uidx] - 2'd1;
      end
    end else begin
      w_nctr = upd_taken ? 2'b10 : 2'b01;
      w_ntgt = upd_target;
    end
  end

  always_comb begin
    w_rv   = r_v[w_lidx];
    w_rtag = r_tag[w_lidx];
    w_rtgt = r_tgt[w_lidx];
    w_rctr = r_ctr[w_lidx];
`ifdef BTB_BYPASS_EN
    if (upd_en && (w_uidx == w_lidx)) begin
      w_rv   = 1'b1;
      w_rtag = w_utag;
      w_rtgt = w_ntgt;
      w_rctr = w_nctr;
    end
`endif
  end

  assign w_hit      = w_rv & (w_rtag == w_ltag);
  assign valid      = w_hit;
  assign prediction = w_hit & w_rctr[1];
  assign target     = w_hit ? w_rtgt : 12'h000;
  assign hit_count  = r_hit_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_ENT; i++) begin
        r_v[i]   <= 1'b0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= '0;
      end
    end else begin
      if (inval) begin
        for (int i = 0; i < N_ENT; i++) r_v[i] <= 1'b0;
      end
      if (upd_en) begin
        r_v[w_uidx]   <= 1'b1;
        r_tag[w_uidx] <= w_utag;
        r_tgt[w_uidx] <= w_ntgt;
        r_ctr[w_uidx] <= w_nctr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_hit_cnt <= 16'h0000;
    end else if (count_en && w_hit) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized + directed bench for branch_target_buffer against a table-of-entries model.
`timescale 1ns/1ps
module tb_branch_target_buffer;

  localparam int IDX_W = 4;
  localparam int NENT  = 1 << IDX_W;

  logic        CLK;
  logic        RSTn;
  logic [11:0] fetch_pc;
  logic        valid;
  logic        prediction;
  logic [11:0] target;
  logic        upd_en;
  logic [11:0] upd_pc;
  logic        upd_taken;
  logic [11:0] upd_target;
  logic        inval;
  logic [15:0] hit_count;
  logic        count_en;

  branch_target_buffer #(.IDX_W(IDX_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .fetch_pc(fetch_pc), .valid(valid),
    .prediction(prediction), .target(target), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .inval(inval), .hit_count(hit_count), .count_en(count_en)
  );

  typedef struct packed {
    logic        v;
    logic [9:0]  tag;
    logic [11:0] tgt;
    logic [1:0]  ctr;
  } ent_t;

  ent_t m_tab [NENT];
  int   m_hc;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic        o_v, o_p;
  logic [11:0] o_t;
  logic [15:0] o_hc;
  bit   bypass;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [11:0] pc);
    return (int'(pc) / 4) % NENT;
  endfunction

  function automatic int tag_of(input logic [11:0] pc);
    return int'(pc) / (4 * NENT);
  endfunction

  // Entry contents after a resolved branch, with invalidation applied first
  function automatic ent_t upd_ent(input ent_t e, input bit inv, input logic [11:0] pc,
                                   input bit tk, input logic [11:0] tgt);
    ent_t r = e;
    if (inv) r.v = 1'b0;
    if (r.v && int'(r.tag) == tag_of(pc)) begin
      if (tk) begin
        if (r.ctr < 2'd3) r.ctr = r.ctr + 2'd1;
        r.tgt = tgt;
      end else if (r.ctr > 2'd0) begin
        r.ctr = r.ctr - 2'd1;
      end
    end else begin
      r.v   = 1'b1;
      r.tag = 10'(tag_of(pc));
      r.tgt = tgt;
      r.ctr = tk ? 2'd2 : 2'd1;
    end
    return r;
  endfunction

  // Entered just after a rising edge; checks at the falling edge, returns just after the next rising edge
  task automatic step(input logic [11:0] fpc, input logic ue, input logic [11:0] upc,
                      input logic tk, input logic [11:0] utgt, input logic inv,
                      input logic ce, input bit do_chk);
    ent_t e;
    bit   ev;
    fetch_pc = fpc; upd_en = ue; upd_pc = upc; upd_taken = tk;
    upd_target = utgt; inval = inv; count_en = ce;
    @(negedge CLK);
    e = m_tab[idx_of(fpc)];
    if (bypass && ue && idx_of(upc) == idx_of(fpc)) e = upd_ent(e, inv, upc, tk, utgt);
    ev = e.v && int'(e.tag) == tag_of(fpc);
    o_v = valid; o_p = prediction; o_t = target; o_hc = hit_count;
    if (do_chk) begin
      chk("valid", 16'(valid), 16'(ev));
      chk("prediction", 16'(prediction), 16'(ev && e.ctr[1]));
      chk("target", 16'(target), ev ? 16'(e.tgt) : 16'h0);
      chk("hit_count", hit_count, 16'(m_hc));
    end
    if (ce && ev) m_hc = (m_hc + 1) % 65536;
    @(posedge CLK);
    if (inv) for (int i = 0; i < NENT; i++) m_tab[i].v = 1'b0;
    if (ue) m_tab[idx_of(upc)] = upd_ent(m_tab[idx_of(upc)], inv, upc, tk, utgt);
    #1;
  endtask

  initial begin
`ifdef BTB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    for (int i = 0; i < NENT; i++) m_tab[i] = '0;
    m_hc = 0;

    // reset with an update pending: must be discarded
    RSTn = 1'b0; fetch_pc = 12'h040; upd_en = 1'b1; upd_pc = 12'h040;
    upd_taken = 1'b1; upd_target = 12'h080; inval = 1'b0; count_en = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_pred", 16'(prediction), 16'h0);
    chk("rst_target", 16'(target), 16'h000);
    chk("rst_hc", hit_count, 16'h0000);
    upd_en = 1'b0;
    RSTn = 1'b1;
    @(posedge CLK); #1;
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 1, 1);
    chk("rst_upd_dropped", 16'(o_v), 16'h0);

    // allocate taken, then hit
    step(12'h3FC, 1, 12'h040, 1, 12'h080, 0, 0, 1);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 1, 1);
    chk("alloc_valid", 16'(o_v), 16'h1);
    chk("alloc_pred", 16'(o_p), 16'h1);
    chk("alloc_target", 16'(o_t), 16'h080);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("hc_one", o_hc, 16'h0001);

    // counter down to 00, then saturate at 11
    repeat (2) step(12'h3FC, 1, 12'h040, 0, 12'h0F0, 0, 0, 1);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("ctr00_pred", 16'(o_p), 16'h0);
    chk("ctr00_target", 16'(o_t), 16'h080);
    repeat (5) step(12'h3FC, 1, 12'h040, 1, 12'h0C0, 0, 0, 1);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("sat_pred", 16'(o_p), 16'h1);
    step(12'h3FC, 1, 12'h040, 0, 12'h000, 0, 0, 1);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("sat_nowrap_pred", 16'(o_p), 16'h1);

    // tag conflict at index 0
    step(12'h3FC, 1, 12'h080, 0, 12'h111, 0, 0, 1);
    step(12'h040, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("conflict_old", 16'(o_v), 16'h0);
    step(12'h080, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("conflict_new_v", 16'(o_v), 16'h1);
    chk("conflict_new_p", 16'(o_p), 16'h0);

    // invalidate together with an update
    step(12'h3FC, 1, 12'h044, 1, 12'h010, 1, 0, 1);
    step(12'h080, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("inval_other", 16'(o_v), 16'h0);
    step(12'h044, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("inval_upd_v", 16'(o_v), 16'h1);
    chk("inval_upd_t", 16'(o_t), 16'h010);

    // same-cycle lookup and update at one index
    step(12'h048, 1, 12'h048, 1, 12'h0AA, 0, 1, 1);
    chk("same_cyc_v", 16'(o_v), bypass ? 16'h1 : 16'h0);
    chk("same_cyc_p", 16'(o_p), bypass ? 16'h1 : 16'h0);

    // random traffic over a small tag pool to create hits and conflicts
    for (int n = 0; n < 600; n++) begin
      logic [11:0] f, u, t;
      f = 12'(($urandom_range(0, 2) << 6) | ($urandom_range(0, NENT - 1) << 2) | $urandom_range(0, 3));
      u = 12'(($urandom_range(0, 2) << 6) | ($urandom_range(0, NENT - 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) u = f;
      t = 12'($urandom);
      step(f, 1'($urandom_range(0, 1)), u, 1'($urandom_range(0, 1)), t,
           $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)), 1);
    end

    // hit_count wrap
    step(12'h3FC, 1, 12'h048, 1, 12'h0AA, 0, 0, 1);
    while (m_hc != 65535) step(12'h048, 0, 12'h000, 0, 12'h000, 0, 1, 0);
    step(12'h048, 0, 12'h000, 0, 12'h000, 0, 1, 1);
    chk("hc_ffff", o_hc, 16'hFFFF);
    step(12'h048, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    chk("hc_wrap", o_hc, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning index width; the table holds 2^IDX_W entries.
REQ-002 SHALL have port CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_pc, input, 12 bits: byte PC of the instruction in IF, used for lookup.
REQ-005 SHALL have port valid, output, 1 bit: a matching valid entry exists for fetch_pc; 0 steers the fetch path to PC+4 (pcSrc 101).
REQ-006 SHALL have port prediction, output, 1 bit: predicted-taken bit for fetch_pc.
REQ-007 SHALL have port target, output, 12 bits: predicted target for fetch_pc.
REQ-008 SHALL have port upd_en, input, 1 bit: EX-stage resolution of a B-type instruction is present this cycle.
REQ-009 SHALL have port upd_pc, input, 12 bits: PC of the resolved branch.
REQ-010 SHALL have port upd_taken, input, 1 bit: actual outcome (the EX branch signal).
REQ-011 SHALL have port upd_target, input, 12 bits: computed target (ALUT_result[11:0]).
REQ-012 SHALL have port inval, input, 1 bit: clears every entry's valid bit at the next edge.
REQ-013 SHALL have port hit_count, output, 16 bits: number of lookups that returned valid=1 while count_en=1.
REQ-014 SHALL have port count_en, input, 1 bit: the IF stage holds a real, unstalled fetch this cycle.

Function
REQ-015 SHALL map index = pc[IDX_W+1:2] and tag = pc[11:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-016 Each entry SHALL hold v (1b), tag, target (12b) and ctr (2b saturating counter).
REQ-017 Lookup SHALL be combinational from registered state: valid = v & (tag match); prediction = valid & ctr[1]; target = stored target when valid, else 0.
REQ-018 On upd_en with a valid tag hit, ctr SHALL increment when taken (saturating at 11) and decrement when not taken (saturating at 00), and target SHALL be overwritten when taken.
REQ-019 On upd_en with a miss (v=0 or tag mismatch), the entry SHALL be allocated: v=1, tag and target written, ctr=10 if taken, else 01.
REQ-020 Updates SHALL take effect at the edge ending the upd_en cycle; single-cycle latency; no backpressure; upd_en is accepted every cycle.
REQ-021 Simultaneous inval and upd_en SHALL resolve inval first, then perform the update: the updated entry ends up valid and all others invalid.
REQ-022 Same-cycle lookup and update at the same index SHALL return pre-update state (see REQ-027 for the exception).
REQ-023 hit_count SHALL increment when count_en & valid, and SHALL wrap from FFFF to 0000.
REQ-024 No X SHALL propagate from the outputs: unallocated entries SHALL read as valid=0, prediction=0, target=0.

Reset
REQ-025 RSTn=0 SHALL asynchronously clear every v, ctr, tag and target, and clear hit_count to 0; outputs SHALL be valid=0, prediction=0, target=0.
REQ-026 Reset asserted in the same cycle as upd_en SHALL discard the update; the first update accepted is at the first edge with RSTn=1.

Configuration
REQ-027 Macro BTB_BYPASS_EN. Defined: when upd_en and the lookup hit the same index in the same cycle, the lookup outputs SHALL reflect the post-update entry (write-through forward). Undefined: REQ-022 applies unchanged.

Verification
REQ-028 Reset, then fetch_pc=0x040 -> valid=0, prediction=0, target=0x000, hit_count=0.
REQ-029 Update pc=0x040 taken, target=0x080; next cycle fetch_pc=0x040 -> valid=1, prediction=1, target=0x080; with count_en=1, hit_count=1.
REQ-030 After REQ-029, two not-taken updates at 0x040 -> ctr 10->01->00 and prediction=0; five taken updates -> ctr saturates at 11 with no wrap.
REQ-031 With IDX_W=4, allocate 0x040, then update 0x080 (same index, different tag) not-taken -> lookup 0x040 gives valid=0; lookup 0x080 gives valid=1, prediction=0.
REQ-032 inval and upd_en (0x044 taken, target 0x010) asserted together -> lookup 0x040 gives valid=0; lookup 0x044 gives valid=1, target=0x010.
REQ-033 Same-cycle update and lookup of 0x048: with the macro undefined -> valid=0 that cycle; with BTB_BYPASS_EN defined -> valid=1, prediction per the new ctr; also preload hit_count=FFFF, one hit -> 0000.
